bitrev_reorder_buf: RTL and testbench
=====================================

# bitrev_reorder_buf

Bit-reversal reorder buffer placed at the output of the FFT core. The core emits one frame of N = 2^LOG2N samples in bit-reversed index order. This block writes each accepted sample at the bit-reversed address of its arrival count, then streams the frame out in natural order (X[0] … X[N-1]). Both sides use valid/ready handshakes; an optional second bank lets a new frame fill while the previous one drains.

## Interface
- LOG2N, 8, log2 of frame length N; legal range 2..10
- DATA_W, 32, sample width (packed re/im); passed through unmodified
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept an input sample
- in_data  input  DATA_W  input sample, bit-reversed order
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts the output sample
- out_data  output  DATA_W  output sample, natural order
- out_last  output  1  high with the final sample (index N-1) of a frame

## Operation
- Storage: NB banks of N × DATA_W registers. NB = 2 with BITREV_PINGPONG_EN, otherwise 1. Memory contents are not reset.
- Per-bank flag full[b]:
  - The bank is EMPTY when full = 0.
  - The bank is FULL when full = 1.
- Pointers:
  - wb: write bank
  - rb: read bank
  - wcnt: write count, LOG2N bits
  - rcnt: read count, LOG2N bits
- in_ready = !full[wb]. An input handshake is in_valid && in_ready.
- On an input handshake:
  - mem[wb][bitrev(wcnt)] <= in_data, where bitrev reverses all LOG2N bits (MSB↔LSB).
  - wcnt increments and wraps from N-1 to 0.
  - If wcnt == N-1: full[wb] <= 1 and wb toggles (NB = 2 only).
- out_valid = full[rb]. out_data = mem[rb][rcnt] (combinational read). out_last = out_valid && (rcnt == N-1).
- On an output handshake (out_valid && out_ready):
  - rcnt increments and wraps.
  - If rcnt == N-1: full[rb] <= 0 and rb toggles (NB = 2 only).
- Writes and reads never target the same bank in the same cycle: writes require EMPTY and reads require FULL.
- The output must stay stable while out_valid && !out_ready. Downstream backpressure stalls only the read side.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_last = 0
  - wcnt = rcnt = 0
  - wb = rb = 0
  - all full = 0
  - out_data is don't-care.
- Latency: out_valid rises in the cycle after the handshake of input sample N-1. X[0] is presented in that same cycle.
- Throughput with NB = 2: one sample per cycle, sustained on both sides.
- Throughput with NB = 1: in_ready is low from the cycle after the last input until the cycle after the last output handshake. Gap between frames is at least N cycles.
- Simultaneous events:
  - Last write into bank A and last read from bank B in the same cycle: both flag updates take effect. The next cycle shows full[A] = 1 and full[B] = 0.
  - Both banks FULL: in_ready = 0 until the read bank completes.
- Reset mid-frame: the partial frame is discarded, all flags clear, and the counters restart at 0. No spurious out_valid follows the release of reset.
- Input in_data is ignored whenever in_ready = 0.

## Configuration
- BITREV_PINGPONG_EN defined:
  - two banks (2·N·DATA_W storage)
  - concurrent fill and drain
  - wb and rb are 1-bit toggling pointers
- BITREV_PINGPONG_EN undefined:
  - single bank
  - wb and rb are tied to 0
  - the block alternates strictly between the fill and drain phases, with in_ready = 0 throughout the drain

## Test plan
- LOG2N=3, write 10..17 continuously, out_ready = 1 → out_data sequence 10,14,12,16,11,15,13,17. out_last is high only on 17. out_valid rises 1 cycle after 17 is accepted.
- LOG2N=3, out_ready toggled 1/0 each cycle → same sequence. out_data and out_last hold steady while stalled.
- BITREV_PINGPONG_EN, LOG2N=3, 4 back-to-back frames with in_valid = out_ready = 1 → in_ready never drops. Outputs are continuous at one per cycle, with out_last every 8th sample.
- BITREV_PINGPONG_EN, out_ready = 0, push 2 frames → in_ready = 0 after the 16th accept. When out_ready is raised, in_ready returns 1 cycle after the 8th output.
- Without the macro, LOG2N=3 → in_ready = 0 for exactly 8 cycles with out_ready = 1. The next frame is accepted starting the cycle after out_last.
- Assert rst_n low after 5 inputs, then send a full frame → there is no output until 8 new samples are accepted. The output contains only the new-frame values in correct order.

Source files
------------

// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf
// Reorder buffer for the FFT core output. Each frame of N = 2^LOG2N samples
// arrives in bit-reversed index order. Every accepted sample is written at the
// bit-reversed address of its arrival count, and the frame is then streamed
// out in natural order X[0] .. X[N-1] over a valid/ready handshake.
//
// Optional feature macro: BITREV_PINGPONG_EN
//   defined   : two banks, a new frame fills while the previous one drains
//   undefined : one bank, the block alternates strictly between fill and drain
//
// Sample storage is never reset; only the flags, pointers and counters are.
module bitrev_reorder_buf #(
    parameter int LOG2N  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int N = 1 << LOG2N;

    // Reverse all LOG2N bits of an index (MSB <-> LSB).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_last;
    logic             rd_last;
    logic [LOG2N-1:0] waddr;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_last = (wcnt == LOG2N'(N - 1));
    assign rd_last = (rcnt == LOG2N'(N - 1));
    assign waddr   = bitrev(wcnt);
    assign out_last = out_valid && rd_last;

`ifdef BITREV_PINGPONG_EN

    logic [DATA_W-1:0] mem [2][N];
    logic [1:0]        full;
    logic              wb;
    logic              rb;

    // A bank is written only while EMPTY and read only while FULL, so the
    // write bank and the read bank can never collide in one cycle.
    assign in_ready  = !full[wb];
    assign out_valid = full[rb];
    assign out_data  = mem[rb][rcnt];

    // Sample storage: scatter each accepted sample to its natural-order slot.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wb][waddr] <= in_data;
        end
    end

    // Bank flags, bank pointers and counters; a frame completing on the write
    // side and one completing on the read side touch different flag bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            rcnt <= '0;
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
        end else begin
            if (wr_fire) begin
                wcnt <= wcnt + LOG2N'(1);
                if (wr_last) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end
            end
            if (rd_fire) begin
                rcnt <= rcnt + LOG2N'(1);
                if (rd_last) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end
        end
    end

`else

    logic [DATA_W-1:0] mem [N];
    logic              full;

    // Single bank: accepting input only while EMPTY and presenting output only
    // while FULL makes fill and drain strictly alternate.
    assign in_ready  = !full;
    assign out_valid = full;
    assign out_data  = mem[rcnt];

    // Sample storage: scatter each accepted sample to its natural-order slot.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[waddr] <= in_data;
        end
    end

    // Bank flag and counters; fill and drain are mutually exclusive here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            rcnt <= '0;
            full <= 1'b0;
        end else begin
            if (wr_fire) begin
                wcnt <= wcnt + LOG2N'(1);
                if (wr_last) begin
                    full <= 1'b1;
                end
            end
            if (rd_fire) begin
                rcnt <= rcnt + LOG2N'(1);
                if (rd_last) begin
                    full <= 1'b0;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Testbench for bitrev_reorder_buf with LOG2N = 3 (N = 8).
// A cycle table covers fill/drain with and without output stalls; hand-written
// sequences cover junk input during drain, reset mid-frame and, when
// BITREV_PINGPONG_EN is defined, back-to-back frames and both-banks-full.
module tb_bitrev_reorder_buf;

    localparam int LOG2N  = 3;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    bitrev_reorder_buf #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
    } vec_t;

    vec_t vt[$];
    int   checks;
    int   failures;
    int   rev3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic drain_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one cycle, then move to 1 time unit after the next edge.
    task automatic cyc(input logic iv, input logic [31:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic void addv(input logic iv, input logic [31:0] id, input logic ordy,
                                 input logic e_irdy, input logic e_ov,
                                 input logic [31:0] e_od, input logic e_ol);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
        vt.push_back(v);
    endfunction

    // Drain a full frame with out_ready = 1 and check natural order.
    task automatic drain_frame(input string name, input int base, input logic e_irdy);
        for (int j = 0; j < 8; j++) begin
            chk({name, " in_ready"}, 32'(in_ready), 32'(e_irdy));
            chk({name, " out_valid"}, 32'(out_valid), 1);
            chk({name, " out_data"}, out_data, 32'(base + rev3[j]));
            chk({name, " out_last"}, 32'(out_last), 32'(j == 7));
            cyc(1'b0, 32'd0, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int o1[8];
        int o2[8];
        int t;
        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
`ifdef BITREV_PINGPONG_EN
        drain_rdy = 1'b1;
`else
        drain_rdy = 1'b0;
`endif
        o1 = '{10, 14, 12, 16, 11, 15, 13, 17};
        o2 = '{20, 24, 22, 26, 21, 25, 23, 27};

        // Table 1: frame 10..17, out_ready = 1 throughout.
        for (int k = 0; k < 8; k++) addv(1'b1, 32'(10 + k), 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int j = 0; j < 8; j++) addv(1'b0, 32'd0, 1'b1, drain_rdy, 1'b1, 32'(o1[j]), 1'(j == 7));
        addv(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        // Table 2: frame 20..27, out_ready toggling 1/0 during drain.
        for (int k = 0; k < 8; k++) addv(1'b1, 32'(20 + k), 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        addv(1'b0, 32'd0, 1'b1, drain_rdy, 1'b1, 32'(o2[0]), 1'b0);
        for (int j = 1; j < 8; j++) begin
            addv(1'b0, 32'd0, 1'b0, drain_rdy, 1'b1, 32'(o2[j]), 1'(j == 7));
            addv(1'b0, 32'd0, 1'b1, drain_rdy, 1'b1, 32'(o2[j]), 1'(j == 7));
        end
        addv(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out_last", 32'(out_last), 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            chk("tbl in_ready", 32'(in_ready), 32'(vt[i].e_irdy));
            chk("tbl out_valid", 32'(out_valid), 32'(vt[i].e_ov));
            chk("tbl out_last", 32'(out_last), 32'(vt[i].e_ol));
            if (vt[i].e_ov) chk("tbl out_data", out_data, vt[i].e_od);
            cyc(vt[i].iv, vt[i].id, vt[i].ordy);
        end

`ifndef BITREV_PINGPONG_EN
        // Single bank: in_valid held high with junk during the drain is ignored.
        for (int k = 0; k < 8; k++) begin
            chk("junk fill in_ready", 32'(in_ready), 1);
            cyc(1'b1, 32'(30 + k), 1'b1);
        end
        for (int j = 0; j < 8; j++) begin
            chk("junk drain in_ready", 32'(in_ready), 0);
            chk("junk drain out_data", out_data, 32'(30 + rev3[j]));
            chk("junk drain out_last", 32'(out_last), 32'(j == 7));
            cyc(1'b1, 32'd99, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            chk("refill in_ready", 32'(in_ready), 1);
            chk("refill out_valid", 32'(out_valid), 0);
            cyc(1'b1, 32'(40 + k), 1'b1);
        end
        drain_frame("refill drain", 40, 1'b0);
`endif

        // Reset mid-frame: the partial frame never appears.
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'(50 + k), 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 1);
        chk("midrst out_valid", 32'(out_valid), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("postrst idle out_valid", 32'(out_valid), 0);
            cyc(1'b0, 32'd0, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            chk("postrst fill out_valid", 32'(out_valid), 0);
            chk("postrst fill in_ready", 32'(in_ready), 1);
            cyc(1'b1, 32'(60 + k), 1'b1);
        end
        drain_frame("postrst drain", 60, drain_rdy);
        chk("postrst end out_valid", 32'(out_valid), 0);

`ifdef BITREV_PINGPONG_EN
        // Four back-to-back frames with in_valid = out_ready = 1.
        do_reset();
        for (t = 0; t <= 40; t++) begin
            if (t < 32) chk("b2b in_ready", 32'(in_ready), 1);
            chk("b2b out_valid", 32'(out_valid), 32'(t >= 8 && t < 40));
            if (t >= 8 && t < 40) begin
                chk("b2b out_data", out_data, 32'(100 + 8 * ((t - 8) / 8) + rev3[(t - 8) % 8]));
                chk("b2b out_last", 32'(out_last), 32'(((t - 8) % 8) == 7));
            end
            cyc(1'(t < 32), 32'(100 + t), 1'b1);
        end

        // Both banks full with out_ready = 0.
        for (t = 0; t < 16; t++) begin
            chk("bothfull fill in_ready", 32'(in_ready), 1);
            chk("bothfull fill out_valid", 32'(out_valid), 32'(t >= 8));
            cyc(1'b1, 32'(200 + t), 1'b0);
        end
        for (t = 16; t < 19; t++) begin
            chk("bothfull stall in_ready", 32'(in_ready), 0);
            chk("bothfull stall out_data", out_data, 200);
            chk("bothfull stall out_last", 32'(out_last), 0);
            cyc(1'b1, 32'd77, 1'b0);
        end
        drain_frame("bothfull drain0", 200, 1'b0);
        drain_frame("bothfull drain1", 208, 1'b1);
        chk("bothfull end out_valid", 32'(out_valid), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
